// File: rtl/tally_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tally_reader
//  Brief    : Reads the four candidate counts out of the voting machine by
//             driving mode/button1..4, samples led for each candidate and
//             hands the counts to a downstream consumer over valid/ready.
//             Optional build macro TALLY_TOTAL_EN adds a running total output.
//  Revision : 1.0  initial release
// ============================================================================
module tally_reader #(
    parameter int SETUP_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int GAP_CYCLES    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] led,
    output logic             mode,
    output logic             button1,
    output logic             button2,
    output logic             button3,
    output logic             button4,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [1:0]       result_id,
    output logic [CNT_W-1:0] result_count,
    output logic             busy,
    output logic             done
`ifdef TALLY_TOTAL_EN
    ,
    output logic [CNT_W+1:0] total_count
`endif
);

    // One shared wait counter covers SETUP, PRESS and GAP; size it for the longest.
    localparam int c_MAX_WAIT = (SETUP_CYCLES > SETTLE_CYCLES)
                              ? ((SETUP_CYCLES > GAP_CYCLES) ? SETUP_CYCLES : GAP_CYCLES)
                              : ((SETTLE_CYCLES > GAP_CYCLES) ? SETTLE_CYCLES : GAP_CYCLES);
    localparam int c_WAIT_W = $clog2(c_MAX_WAIT + 1);
    localparam logic [c_WAIT_W-1:0] c_SETUP_LAST  = c_WAIT_W'(SETUP_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0] c_SETTLE_LAST = c_WAIT_W'(SETTLE_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0] c_GAP_LAST    = c_WAIT_W'(GAP_CYCLES - 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_ONE    = c_WAIT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_PRESS   = 3'd2,
        S_CAPTURE = 3'd3,
        S_OFFER   = 3'd4,
        S_GAP     = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    state_t              r_state,  w_state;
    logic [c_WAIT_W-1:0] r_wait,   w_wait;
    logic [1:0]          r_idx,    w_idx;
    logic                r_mode,   w_mode;
    logic [3:0]          r_btn,    w_btn;
    logic                r_valid,  w_valid;
    logic [1:0]          r_id,     w_id;
    logic [CNT_W-1:0]    r_count,  w_count;
    logic                r_busy,   w_busy;
    logic                r_done,   w_done;
`ifdef TALLY_TOTAL_EN
    localparam int c_TOT_W = CNT_W + 2;
    logic [c_TOT_W-1:0]  r_total,  w_total;
`endif

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_state = r_state;
        w_wait  = r_wait + c_WAIT_ONE;
        w_idx   = r_idx;
        w_mode  = r_mode;
        w_btn   = r_btn;
        w_valid = r_valid;
        w_id    = r_id;
        w_count = r_count;
        w_busy  = r_busy;
        w_done  = 1'b0;
`ifdef TALLY_TOTAL_EN
        w_total = r_total;
`endif
        case (r_state)
            S_IDLE: begin
                w_wait = '0;
                if (start) begin
                    w_state = S_SETUP;
                    w_mode  = 1'b1;
                    w_busy  = 1'b1;
                    w_idx   = 2'd0;
`ifdef TALLY_TOTAL_EN
                    w_total = '0;
`endif
                end
            end
            S_SETUP: begin
                if (r_wait == c_SETUP_LAST) begin
                    w_state = S_PRESS;
                    w_wait  = '0;
                    w_btn   = 4'b0001 << r_idx;
                end
            end
            S_PRESS: begin
                // led is taken on the last pressed cycle while the button is still down.
                if (r_wait == c_SETTLE_LAST) begin
                    w_state = S_CAPTURE;
                    w_wait  = '0;
                    w_btn   = 4'b0000;
                    w_count = led;
                    w_id    = r_idx;
                end
            end
            S_CAPTURE: begin
                w_state = S_OFFER;
                w_wait  = '0;
                w_valid = 1'b1;
            end
            S_OFFER: begin
                w_wait = '0;
                if (r_valid && result_ready) begin
                    w_state = S_GAP;
                    w_valid = 1'b0;
`ifdef TALLY_TOTAL_EN
                    w_total = r_total + c_TOT_W'(r_count);
`endif
                end
            end
            S_GAP: begin
                if (r_wait == c_GAP_LAST) begin
                    w_wait = '0;
                    if (r_idx == 2'd3) begin
                        w_state = S_FINISH;
                    end else begin
                        w_state = S_PRESS;
                        w_idx   = r_idx + 2'd1;
                        w_btn   = 4'b0001 << (r_idx + 2'd1);
                    end
                end
            end
            S_FINISH: begin
                w_state = S_IDLE;
                w_wait  = '0;
                w_mode  = 1'b0;
                w_busy  = 1'b0;
                w_done  = 1'b1;
            end
            default: begin
                w_state = S_IDLE;
                w_wait  = '0;
            end
        endcase
    end

    // State and output registers with synchronous reset taking priority.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_idx   <= 2'd0;
            r_mode  <= 1'b0;
            r_btn   <= 4'b0000;
            r_valid <= 1'b0;
            r_id    <= 2'd0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef TALLY_TOTAL_EN
            r_total <= '0;
`endif
        end else begin
            r_state <= w_state;
            r_wait  <= w_wait;
            r_idx   <= w_idx;
            r_mode  <= w_mode;
            r_btn   <= w_btn;
            r_valid <= w_valid;
            r_id    <= w_id;
            r_count <= w_count;
            r_busy  <= w_busy;
            r_done  <= w_done;
`ifdef TALLY_TOTAL_EN
            r_total <= w_total;
`endif
        end
    end

    assign mode         = r_mode;
    assign button1      = r_btn[0];
    assign button2      = r_btn[1];
    assign button3      = r_btn[2];
    assign button4      = r_btn[3];
    assign result_valid = r_valid;
    assign result_id    = r_id;
    assign result_count = r_count;
    assign busy         = r_busy;
    assign done         = r_done;
`ifdef TALLY_TOTAL_EN
    assign total_count  = r_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tally_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tally_reader
//  Brief    : Self-checking bench for tally_reader with a behavioural voting
//             machine and a timing/sequence model of the readout.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tally_reader;

    localparam int c_W      = 8;
    localparam int c_SETUP  = 4;
    localparam int c_SETTLE = 8;
    localparam int c_GAP    = 4;
    // start sampled -> first valid; accept -> next valid; last accept -> done
    localparam int c_FIRST  = 1 + c_SETUP + c_SETTLE + 1;
    localparam int c_NEXT   = 1 + c_GAP + c_SETTLE + 1;
    localparam int c_TAIL   = 1 + c_GAP + 1;

    logic           clock = 1'b0;
    logic           reset, start, result_ready;
    logic [c_W-1:0] led;
    logic           mode, button1, button2, button3, button4;
    logic           result_valid;
    logic [1:0]     result_id;
    logic [c_W-1:0] result_count;
    logic           busy, done;
`ifdef TALLY_TOTAL_EN
    logic [c_W+1:0] total_count;
`endif

    logic [c_W-1:0] votes [4];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Voting machine: shows the selected candidate's count in result mode.
    assign led = !mode   ? '0 :
                 button1 ? votes[0] :
                 button2 ? votes[1] :
                 button3 ? votes[2] :
                 button4 ? votes[3] : '0;

    wire [3:0] w_btns = {button4, button3, button2, button1};

    tally_reader #(
        .SETUP_CYCLES (c_SETUP),
        .SETTLE_CYCLES(c_SETTLE),
        .GAP_CYCLES   (c_GAP),
        .CNT_W        (c_W)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .led         (led),
        .mode        (mode),
        .button1     (button1),
        .button2     (button2),
        .button3     (button3),
        .button4     (button4),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_id   (result_id),
        .result_count(result_count),
        .busy        (busy),
        .done        (done)
`ifdef TALLY_TOTAL_EN
        ,
        .total_count (total_count)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act_v, input logic [63:0] exp_v);
        n_cmp++;
        if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act_v, exp_v, cyc);
        end
    endtask

    // Readout model state
    bit m_act      = 1'b0;
    bit m_rst_seen = 1'b0;
    int m_nres     = 0;
    int m_tv       = 0;
    int m_tdone    = -1;
    int m_tstart   = 0;
    int m_tot      = 0;
    // Observations of the DUT for the hand-computed checks
    int rec_fv     = -1;
    int rec_done   = -1;
    int rec_n      = 0;
    int d_cnt      = 0;
    int rec_cnt [4];

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin : p_compare
        logic       exp_v;
        logic [3:0] exp_btn;
        if (cyc == m_tdone) m_act = 1'b0;
        exp_v   = m_act && (m_nres < 4) && (cyc >= m_tv);
        exp_btn = (m_act && (m_nres < 4) && (cyc >= m_tv - c_SETTLE - 1) && (cyc <= m_tv - 2))
                ? (4'b0001 << m_nres) : 4'b0000;

        if (m_rst_seen)
            chk("reset_values", {mode, w_btns, result_valid, result_id, result_count, busy, done}, 64'd0);
        chk("busy", busy, m_act);
        chk("mode", mode, m_act);
        chk("done", done, cyc == m_tdone);
        chk("result_valid", result_valid, exp_v);
        chk("buttons", w_btns, exp_btn);
        chk("button_exclusive", ($countones(w_btns) <= 1) && !((w_btns != 4'b0000) && !mode), 1);
        if (exp_v) begin
            chk("result_id", result_id, m_nres);
            chk("result_count", result_count, votes[m_nres]);
        end
`ifdef TALLY_TOTAL_EN
        if (cyc == m_tdone) chk("total_count", total_count, m_tot);
`endif

        if (done === 1'b1) begin
            d_cnt++;
            rec_done = cyc;
        end
        if (result_valid === 1'b1 && rec_fv < 0) rec_fv = cyc;
        if (result_valid === 1'b1 && result_ready && !reset && rec_n < 4) begin
            rec_cnt[rec_n] = result_count;
            rec_n++;
        end

        if (reset) begin
            m_act      = 1'b0;
            m_nres     = 0;
            m_tdone    = -1;
            m_rst_seen = 1'b1;
        end else begin
            m_rst_seen = 1'b0;
            if (exp_v && result_ready) begin
                m_tot += votes[m_nres];
                m_nres++;
                if (m_nres < 4) m_tv = cyc + c_NEXT;
                else            m_tdone = cyc + c_TAIL;
            end
            if (!m_act && start) begin
                m_act    = 1'b1;
                m_tstart = cyc;
                m_tv     = cyc + c_FIRST;
                m_nres   = 0;
                m_tot    = 0;
                m_tdone  = -1;
                rec_fv   = -1;
                rec_n    = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n0 = d_cnt;
        int k  = 0;
        while (d_cnt == n0 && k < limit) begin
            tick();
            k++;
        end
        chk("done_within_bound", d_cnt != n0, 1);
    endtask

    initial begin : p_watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : p_stim
        int k;
        int n0;
        reset        = 1'b1;
        start        = 1'b0;
        result_ready = 1'b1;
        votes        = '{8'd3, 8'd5, 8'd0, 8'd255};
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Basic readout, ready tied high
        n0 = d_cnt;
        pulse_start();
        wait_done(200);
        repeat (5) tick();
        chk("basic_first_valid_latency", rec_fv - m_tstart, 14);
        chk("basic_done_latency", rec_done - m_tstart, 62);
        chk("basic_count_id0", rec_cnt[0], 3);
        chk("basic_count_id1", rec_cnt[1], 5);
        chk("basic_count_id2", rec_cnt[2], 0);
        chk("basic_count_id3", rec_cnt[3], 255);
        chk("basic_done_pulses", d_cnt - n0, 1);
        chk("basic_mode_after", mode, 0);
`ifdef TALLY_TOTAL_EN
        chk("basic_total", total_count, 263);
`endif

        // Backpressure on id1
        pulse_start();
        k = 0;
        while (!(result_valid === 1'b1 && result_id == 2'd1) && k < 100) begin
            tick();
            k++;
        end
        chk("bp_reached_id1", result_valid === 1'b1 && result_id == 2'd1, 1);
        result_ready = 1'b0;
        repeat (20) tick();
        chk("bp_hold_valid", result_valid, 1);
        chk("bp_hold_id", result_id, 1);
        chk("bp_hold_count", result_count, 5);
        chk("bp_hold_mode", mode, 1);
        chk("bp_hold_buttons", w_btns, 0);
        result_ready = 1'b1;
        wait_done(200);
        chk("bp_count_id2", rec_cnt[2], 0);
        chk("bp_count_id3", rec_cnt[3], 255);

        // Reset while candidate 3 is pressed
        votes = '{8'd10, 8'd20, 8'd30, 8'd40};
        pulse_start();
        k = 0;
        while (button3 !== 1'b1 && k < 100) begin
            tick();
            k++;
        end
        chk("rst_reached_press_id2", button3, 1);
        n0    = d_cnt;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mode", mode, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_buttons", w_btns, 0);
        repeat (80) tick();
        chk("rst_no_done", d_cnt - n0, 0);
        pulse_start();
        wait_done(200);
        chk("rst_rerun_id0", rec_cnt[0], 10);
        chk("rst_rerun_id1", rec_cnt[1], 20);
        chk("rst_rerun_id2", rec_cnt[2], 30);
        chk("rst_rerun_id3", rec_cnt[3], 40);

        // start pulsed while busy is ignored
        n0 = d_cnt;
        pulse_start();
        repeat (30) tick();
        pulse_start();
        wait_done(200);
        repeat (80) tick();
        chk("busy_start_single_done", d_cnt - n0, 1);
        chk("busy_start_four_results", rec_n, 4);

        // start held high: back-to-back readouts
        n0    = d_cnt;
        start = 1'b1;
        wait_done(200);
        wait_done(200);
        start = 1'b0;
        wait_done(200);
        chk("held_start_readouts", d_cnt - n0, 3);

        // Randomized counts, ready and spurious starts
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 4; i++) votes[i] = 8'($urandom_range(0, 255));
            if (r % 2 == 0) votes[r % 4] = 8'd255;
            n0 = d_cnt;
            pulse_start();
            k = 0;
            while (d_cnt == n0 && k < 3000) begin
                result_ready = ($urandom_range(0, 2) != 0);
                start        = m_act && (m_nres < 4) && ($urandom_range(0, 15) == 0);
                tick();
                k++;
            end
            start        = 1'b0;
            result_ready = 1'b1;
            chk("rand_done_within_bound", d_cnt != n0, 1);
            repeat (3) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
